pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage RV32 pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-register enable/flush each cycle from load-use hazards, EX-stage redirects, data-memory wait and HALT.
- Runs a halt-drain FSM so that older instructions retire before the core freezes.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer for the 5-stage RV32 core.
// Resolves load-use, redirect, memory wait and halt-drain; counts stalls/flushes.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             id_ex_halt,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic memstall;
    logic loaduse;
    logic in_run;
    logic in_halted;
    logic do_halt;
    logic do_redirect;
    logic do_loaduse;
    logic stall_inc;
    logic flush_inc;

    assign memstall = mem_access & ~dmem_ready;
    assign loaduse  = id_ex_memread & (id_ex_rd != 5'd0)
                    & ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

    assign in_run    = (state_q == RUN);
    assign in_halted = (state_q == HALTED);

    assign do_halt     = in_run & ~memstall & id_ex_halt;
    assign do_redirect = in_run & ~memstall & ~id_ex_halt & ex_redirect;
    assign do_loaduse  = in_run & ~memstall & ~id_ex_halt & ~ex_redirect
                       & loaduse;

    assign stall_inc = (~in_halted & memstall) | do_loaduse;
    assign flush_inc = do_redirect;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        mem_wb_flush = 1'b0;
        if (in_halted) begin
            pc_en = 1'b0;
        end else if (memstall) begin
            // Only MEM/WB advances, taking a bubble behind the waiting access.
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (!in_run || do_halt) begin
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else if (do_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else if (do_loaduse) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (do_halt) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
        end else if (state_q == DRAIN && !memstall) begin
            if (drain_q == 4'd0) begin
                state_d = HALTED;
            end else begin
                drain_d = drain_q - 4'd1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush_inc && flush_q != {CNT_W{1'b1}}) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted    = in_halted;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, drain FSM, counters.
// A CNT_W=4 instance shares the stimulus for the saturation case.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic id_ex_memread, id_ex_halt, ex_redirect;
    logic mem_access, dmem_ready;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, mem_wb_en, mem_wb_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
    logic s_ex_mem_en, s_mem_wb_en, s_mem_wb_flush, s_halted;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] NORMAL  = 8'b1101_0110;
    localparam logic [7:0] LOADUSE = 8'b0001_1110;
    localparam logic [7:0] REDIR   = 8'b1111_1110;
    localparam logic [7:0] MSTALL  = 8'b0000_0011;
    localparam logic [7:0] DRAINP  = 8'b0111_1110;
    localparam logic [7:0] FROZEN  = 8'b0000_0000;

    logic [7:0] ctl;
    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en,
                  id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .id_ex_halt(id_ex_halt), .ex_redirect(ex_redirect),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .mem_wb_flush(mem_wb_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .id_ex_halt(id_ex_halt), .ex_redirect(ex_redirect),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
        .mem_wb_flush(s_mem_wb_flush), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_id_rs1 = 5'd0;
        if_id_rs2 = 5'd0;
        id_ex_rd = 5'd0;
        id_ex_memread = 1'b0;
        id_ex_halt = 1'b0;
        ex_redirect = 1'b0;
        mem_access = 1'b0;
        dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ctl !== NORMAL) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, NORMAL);
        end
        checks++;
        if ({halted, stall_cnt, flush_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state halted=%b stall=%0d flush=%0d exp 0",
                     halted, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_loaduse();
        id_ex_memread = 1'b1;
        id_ex_rd = 5'd5;
        if_id_rs2 = 5'd5;
        #1;
        checks++;
        if (ctl !== LOADUSE) begin
            errors++;
            $display("FAIL loaduse_ctl got=%b exp=%b", ctl, LOADUSE);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL loaduse_cnt got=%0d exp=1", stall_cnt);
        end
        checks++;
        if (ctl !== NORMAL) begin
            errors++;
            $display("FAIL loaduse_clear got=%b exp=%b", ctl, NORMAL);
        end
    endtask

    task automatic test_rd0();
        id_ex_memread = 1'b1;
        id_ex_rd = 5'd0;
        if_id_rs1 = 5'd0;
        #1;
        checks++;
        if (ctl !== NORMAL) begin
            errors++;
            $display("FAIL rd0_ctl got=%b exp=%b", ctl, NORMAL);
        end
        tick();
        idle();
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rd0_cnt got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_redirect();
        id_ex_memread = 1'b1;
        id_ex_rd = 5'd7;
        if_id_rs1 = 5'd7;
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (ctl !== REDIR) begin
            errors++;
            $display("FAIL redirect_ctl got=%b exp=%b", ctl, REDIR);
        end
        tick();
        idle();
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL redirect_cnt flush=%0d stall=%0d exp 1/1",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_memwait();
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== MSTALL) begin
                errors++;
                $display("FAIL memwait_ctl%0d got=%b exp=%b", i, ctl, MSTALL);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== NORMAL) begin
            errors++;
            $display("FAIL memwait_release got=%b exp=%b", ctl, NORMAL);
        end
        checks++;
        if (stall_cnt !== 16'd4) begin
            errors++;
            $display("FAIL memwait_cnt got=%0d exp=4", stall_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_halt_drain();
        logic [15:0] sc;
        id_ex_halt = 1'b1;
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (ctl !== DRAINP) begin
            errors++;
            $display("FAIL halt_ctl got=%b exp=%b", ctl, DRAINP);
        end
        tick();
        idle();
        ex_redirect = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (ctl !== DRAINP || halted !== 1'b0) begin
                errors++;
                $display("FAIL drain_c%0d ctl=%b halted=%b exp=%b/0",
                         c, ctl, halted, DRAINP);
            end
            tick();
        end
        idle();
        checks++;
        if (halted !== 1'b1 || ctl !== FROZEN || flush_cnt !== 16'd1) begin
            errors++;
            $display("FAIL halted_c4 halted=%b ctl=%b flush=%0d exp 1/%b/1",
                     halted, ctl, flush_cnt, FROZEN);
        end
        sc = stall_cnt;
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (ctl !== FROZEN || stall_cnt !== sc || halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_memstall ctl=%b stall=%0d exp %b/%0d",
                     ctl, stall_cnt, FROZEN, sc);
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || ctl !== NORMAL || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_halted halted=%b ctl=%b stall=%0d",
                     halted, ctl, stall_cnt);
        end
    endtask

    task automatic test_halt_memstall();
        logic [6:0] hexp;
        logic [6:0] hgot;
        hexp = 7'b1000000;
        hgot = '0;
        id_ex_halt = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c == 1) idle();
            if (c == 2) begin
                mem_access = 1'b1;
                dmem_ready = 1'b0;
            end
            if (c == 4) idle();
            #1;
            hgot[c] = halted;
            if (c == 2) begin
                checks++;
                if (ctl !== MSTALL) begin
                    errors++;
                    $display("FAIL drain_mstall got=%b exp=%b", ctl, MSTALL);
                end
            end
            tick();
        end
        checks++;
        if (hgot !== hexp) begin
            errors++;
            $display("FAIL halt_delay halted_by_cycle=%b exp=%b", hgot, hexp);
        end
        do_reset();
        id_ex_halt = 1'b1;
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || ctl !== NORMAL || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drain halted=%b ctl=%b stall=%0d",
                     halted, ctl, stall_cnt);
        end
        tick();
        tick();
        tick();
        checks++;
        if (halted !== 1'b0 || ctl !== NORMAL) begin
            errors++;
            $display("FAIL after_reset_drain halted=%b ctl=%b", halted, ctl);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        idle();
        #1;
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt got=%0d exp=15", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL wide_cnt got=%0d exp=20", stall_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_loaduse();
        test_rd0();
        test_redirect();
        test_memwait();
        test_halt_drain();
        test_halt_memstall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
